// File: rtl/sr_cmd_ctrl.sv
// Button front end for an sr_ff. Synchronises and debounces two raw buttons, edge-detects presses,
// arbitrates them and issues single s/r pulses, skipping commands the flop's q already reflects.
module sr_cmd_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 1,
   parameter int HOLDOFF_CYCLES  = 2,
   parameter bit CLR_PRIORITY    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic set_btn,
   input  logic clr_btn,
   input  logic q_fb,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict,
   output logic redundant
);

   // state      | meaning
   // IDLE       | waiting for a pending request
   // SET_PULSE  | driving s for PULSE_CYCLES
   // CLR_PULSE  | driving r for PULSE_CYCLES
   // HOLDOFF    | quiet gap before the next command
   typedef enum logic [1:0] {IDLE, SET_PULSE, CLR_PULSE, HOLDOFF} state_t;

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CYCLES - 1);

   // channel 0 = set, channel 1 = clear
   logic [1:0]             btn;
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [DB_W-1:0]        db_cnt [2];
   logic [1:0]             deb_q;
   logic [1:0]             deb_d1;
   logic [1:0]             rise;
   logic [1:0]             pend_q;
   logic [1:0]             pend_clr;
   state_t                 state_q;
   state_t                 state_n;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_n;
   logic                   conflict_n;
   logic                   redundant_n;
   logic                   win_clr;

   assign btn     = {clr_btn, set_btn};
   assign rise    = deb_q & ~deb_d1;
   assign win_clr = pend_q[1] & (~pend_q[0] | CLR_PRIORITY);
   assign busy    = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            sync_q[ch] <= '0;
            db_cnt[ch] <= '0;
         end
         deb_q  <= '0;
         deb_d1 <= '0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], btn[ch]};
            // level accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (sync_q[ch][SYNC_STAGES-1] == deb_q[ch]) begin
               db_cnt[ch] <= '0;
            end else if (db_cnt[ch] == DB_LAST) begin
               db_cnt[ch] <= '0;
               deb_q[ch]  <= ~deb_q[ch];
            end else begin
               db_cnt[ch] <= db_cnt[ch] + DB_W'(1);
            end
         end
         deb_d1 <= deb_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         s         <= 1'b0;
         r         <= 1'b0;
         conflict  <= 1'b0;
         redundant <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         pend_q    <= (pend_q & ~pend_clr) | rise;
         s         <= (state_n == SET_PULSE);
         r         <= (state_n == CLR_PULSE);
         conflict  <= conflict_n;
         redundant <= redundant_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      pend_clr    = '0;
      conflict_n  = 1'b0;
      redundant_n = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pend_q != 2'b00) begin
               // winner is serviced or dropped, loser is discarded: all pending clears
               pend_clr   = pend_q;
               conflict_n = &pend_q;
               if (win_clr ? ~q_fb : q_fb) begin
                  redundant_n = 1'b1;
               end else begin
                  state_n = win_clr ? CLR_PULSE : SET_PULSE;
                  cnt_n   = PULSE_LD;
               end
            end
         end
         SET_PULSE, CLR_PULSE: begin
            if (cnt_q == '0) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n = HOLDOFF;
                  cnt_n   = HOLD_LD;
               end
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         HOLDOFF: begin
            if (cnt_q == '0) state_n = IDLE;
            else             cnt_n   = cnt_q - CNT_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sr_cmd_ctrl.sv
// Scoreboard bench for sr_cmd_ctrl: a timeline-level reference model predicts every cycle in which
// any output is high; a forked monitor compares DUT outputs on the falling edge.
module tb_sr_cmd_ctrl;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int PUL  = 1;
   localparam int HOLD = 2;
   localparam bit CLRP = 1'b1;
   localparam int MAXC = 16384;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic set_btn = 1'b0;
   logic clr_btn = 1'b0;
   logic q_fb = 1'b0;
   logic s, r, busy, conflict, redundant;

   sr_cmd_ctrl #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL),
      .HOLDOFF_CYCLES(HOLD), .CLR_PRIORITY(CLRP)
   ) dut (
      .clk(clk), .reset(reset), .set_btn(set_btn), .clr_btn(clr_btn), .q_fb(q_fb),
      .s(s), .r(r), .busy(busy), .conflict(conflict), .redundant(redundant)
   );

   always #5 clk = ~clk;

   // expected output vector bits: {s, r, conflict, redundant, busy}
   typedef struct {
      int         cyc;
      logic [4:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   hist [0:1][0:MAXC-1];
   int   last_rst = 0;
   bit [1:0] m_deb = '0;
   bit [1:0] m_rose = '0;
   bit [1:0] m_pend = '0;
   int   next_dec = 0;
   int   kind = 0;
   int   p_start = 0;

   int   cnt_s = 0, cnt_r = 0, cnt_c = 0, cnt_d = 0, cnt_b = 0;
   int   last_s_cyc = 0, last_r_cyc = 0;
   int   b_s, b_r, b_c, b_d, b_b;
   logic s_prev = 1'b0, r_prev = 1'b0;
   int   start;

   // Called right after each rising edge with the inputs that edge sampled.
   task automatic model_edge();
      bit [1:0]   samp;
      bit [1:0]   new_deb;
      bit         win_clr;
      bit         all_diff;
      bit         v;
      logic [4:0] ev;
      cyc++;
      samp = {clr_btn, set_btn};
      for (int ch = 0; ch < 2; ch++) hist[ch][cyc] = samp[ch];
      if (reset) begin
         last_rst = cyc;
         m_deb    = '0;
         m_rose   = '0;
         m_pend   = '0;
         kind     = 0;
         next_dec = cyc + 1;
         return;
      end
      ev = '0;
      if (cyc >= next_dec && m_pend != 2'b00) begin
         win_clr = m_pend[1] && (!m_pend[0] || CLRP);
         ev[2]   = (m_pend == 2'b11);
         if (win_clr ? !q_fb : q_fb) begin
            ev[1]    = 1'b1;
            next_dec = cyc + 1;
         end else begin
            kind     = win_clr ? 2 : 1;
            p_start  = cyc;
            next_dec = cyc + PUL + HOLD + 1;
         end
         m_pend = '0;
      end
      m_pend |= m_rose;
      // a level is accepted once the last DEB synchronised samples all disagree with it
      new_deb = m_deb;
      for (int ch = 0; ch < 2; ch++) begin
         all_diff = 1'b1;
         for (int j = cyc - SYNC - DEB + 1; j <= cyc - SYNC; j++) begin
            v = (j > last_rst) ? hist[ch][j] : 1'b0;
            if (v == m_deb[ch]) all_diff = 1'b0;
         end
         if (all_diff) new_deb[ch] = ~m_deb[ch];
      end
      m_rose = new_deb & ~m_deb;
      m_deb  = new_deb;
      if (kind == 1 && cyc < p_start + PUL) ev[4] = 1'b1;
      if (kind == 2 && cyc < p_start + PUL) ev[3] = 1'b1;
      if (kind != 0 && cyc < p_start + PUL + HOLD) ev[0] = 1'b1;
      if (ev != 5'b0) exp_q.push_back('{cyc, ev});
   endtask

   task automatic monitor();
      logic [4:0] got;
      exp_t       e;
      forever begin
         @(negedge clk);
         got = {s, r, conflict, redundant, busy};
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got !== e.v) begin
               n_fail++;
               $display("FAIL scoreboard cyc=%0d {s,r,conflict,redundant,busy} got %b expected %b", cyc, got, e.v);
            end
         end else if (got !== 5'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard cyc=%0d {s,r,conflict,redundant,busy} got %b expected 00000", cyc, got);
         end
         n_chk++;
         if ((s & r) !== 1'b0) begin
            n_fail++;
            $display("FAIL exclusive cyc=%0d s=%b r=%b", cyc, s, r);
         end
         if (s === 1'b1 && s_prev !== 1'b1) begin cnt_s++; last_s_cyc = cyc; end
         if (r === 1'b1 && r_prev !== 1'b1) begin cnt_r++; last_r_cyc = cyc; end
         if (conflict === 1'b1)  cnt_c++;
         if (redundant === 1'b1) cnt_d++;
         if (busy === 1'b1)      cnt_b++;
         s_prev = s;
         r_prev = r;
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
      end
   endtask

   task automatic check_int(input string name, input int got, input int expv);
      n_chk++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", name, got, expv);
      end
   endtask

   task automatic snap();
      b_s = cnt_s; b_r = cnt_r; b_c = cnt_c; b_d = cnt_d; b_b = cnt_b;
   endtask

   task automatic check_counts(input string name, input int es, input int er, input int ec, input int ed);
      check_int({name, " s_pulses"},   cnt_s - b_s, es);
      check_int({name, " r_pulses"},   cnt_r - b_r, er);
      check_int({name, " conflicts"},  cnt_c - b_c, ec);
      check_int({name, " redundants"}, cnt_d - b_d, ed);
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset with both buttons held; set stays held afterwards
      reset = 1'b1; set_btn = 1'b1; clr_btn = 1'b1; q_fb = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check_int("reset s", int'(s), 0);
         check_int("reset r", int'(r), 0);
         check_int("reset busy", int'(busy), 0);
      end
      reset = 1'b0; clr_btn = 1'b0;
      start = cyc;
      snap();
      tick(20);
      check_counts("after_reset", 1, 0, 0, 0);
      check_int("after_reset latency", last_s_cyc - start, 8);
      set_btn = 1'b0;
      tick(12);

      // clean set press
      snap();
      set_btn = 1'b1;
      start = cyc;
      tick(20);
      set_btn = 1'b0;
      tick(12);
      check_counts("clean_set", 1, 0, 0, 0);
      check_int("clean_set latency", last_s_cyc - start, 8);
      check_int("clean_set busy_cycles", cnt_b - b_b, PUL + HOLD);

      // bouncing input never reaches the debounce threshold
      snap();
      for (int i = 0; i < 4; i++) begin
         set_btn = 1'b1; tick(2);
         set_btn = 1'b0; tick(2);
      end
      tick(12);
      check_counts("bounce", 0, 0, 0, 0);
      snap();
      set_btn = 1'b1; tick(10);
      set_btn = 1'b0; tick(14);
      check_counts("bounce_then_hold", 1, 0, 0, 0);

      // simultaneous presses, clear has priority
      q_fb = 1'b1;
      snap();
      set_btn = 1'b1; clr_btn = 1'b1; tick(14);
      set_btn = 1'b0; clr_btn = 1'b0; tick(14);
      check_counts("simultaneous", 0, 1, 1, 0);

      // set while q already 1
      snap();
      set_btn = 1'b1; tick(12);
      set_btn = 1'b0; tick(12);
      check_counts("redundant", 0, 0, 0, 1);
      check_int("redundant busy_cycles", cnt_b - b_b, 0);

      // clear queued behind a set; q follows the set pulse
      q_fb = 1'b0;
      snap();
      set_btn = 1'b1; tick(2);
      clr_btn = 1'b1; tick(7);
      q_fb = 1'b1; tick(13);
      set_btn = 1'b0; clr_btn = 1'b0; tick(12);
      check_counts("queued", 1, 1, 0, 0);
      check_int("queued s_to_r", last_r_cyc - last_s_cyc, PUL + HOLD + 1);

      // same sequence, reset asserted during the set pulse
      q_fb = 1'b0;
      snap();
      set_btn = 1'b1; tick(2);
      clr_btn = 1'b1; tick(6);
      check_int("midreset s_before", int'(s), 1);
      reset = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
      tick(1);
      check_int("midreset s_after", int'(s), 0);
      check_int("midreset busy_after", int'(busy), 0);
      reset = 1'b0;
      tick(20);
      check_counts("midreset", 1, 0, 0, 0);

      // random buttons, feedback and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)   set_btn = ~set_btn;
         if ($urandom_range(0, 5) == 0)   clr_btn = ~clr_btn;
         if ($urandom_range(0, 15) == 0)  q_fb = ~q_fb;
         reset = ($urandom_range(0, 249) == 0);
         tick(1);
      end
      reset = 1'b0; set_btn = 1'b0; clr_btn = 1'b0;
      tick(30);
      #10;
      check_int("scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
